// File: rtl/i2c_slave_addr_frontend.sv
// I2C slave receive front end: pin synchronisers, START/STOP decode, address phase and ACK.
// Define I2C_GENERAL_CALL_EN to also accept the general-call address byte 8'h00.
module i2c_slave_addr_frontend #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic FPGA_clk,
    input  logic rst,
    input  logic SCL_in,
    input  logic SDA_in,
    input  logic data_done,
    output logic SCL,
    output logic SDA,
    output logic SCL_prev,
    output logic SDA_prev,
    output logic enable,
    output logic SDA_down,
    output logic rw,
    output logic addr_match,
    output logic busy
);

    // state  | meaning
    // IDLE   | bus free, waiting for START
    // ADDR   | shifting in the address byte, MSB first
    // ACK    | address accepted, holding SDA low through the 9th clock
    // DATA   | data-in stage owns the bus until data_done
    // IGNORE | not addressed or transfer finished, waiting for STOP/START
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK    = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       byte_full, byte_full_next;
    logic [7:0] shreg, shreg_next;
    logic       rw_next, enable_next, sda_down_next, match_next;
    logic       scl_rise, scl_fall, start_evt, stop_evt, accept;

    // Synchronisers reset to 1 so an idle bus produces no spurious edges.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            SCL_prev <= 1'b1;
            SDA_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
            SCL_prev <= SCL;
            SDA_prev <= SDA;
        end
    end

    assign SCL = scl_sync[SYNC_STAGES-1];
    assign SDA = sda_sync[SYNC_STAGES-1];

    assign scl_rise  = !SCL_prev && SCL;
    assign scl_fall  = SCL_prev && !SCL;
    assign start_evt = SCL_prev && SCL && SDA_prev && !SDA;
    assign stop_evt  = SCL_prev && SCL && !SDA_prev && SDA;

    // Only writes are acknowledged; a read request falls through to IGNORE.
    always_comb begin
        accept = (shreg[7:1] == SLAVE_ADDR) && !shreg[0];
`ifdef I2C_GENERAL_CALL_EN
        if (shreg == 8'h00) accept = 1'b1;
`endif
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        byte_full_next = byte_full;
        shreg_next     = shreg;
        rw_next        = rw;
        enable_next    = enable;
        sda_down_next  = SDA_down;
        match_next     = 1'b0;
        if (stop_evt) begin
            state_next     = IDLE;
            bit_cnt_next   = 3'd0;
            byte_full_next = 1'b0;
            enable_next    = 1'b0;
            sda_down_next  = 1'b0;
        end else if (start_evt) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            byte_full_next = 1'b0;
            enable_next    = 1'b0;
            sda_down_next  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && !byte_full) begin
                        shreg_next = {shreg[6:0], SDA};
                        if (bit_cnt == 3'd7) begin
                            byte_full_next = 1'b1;
                            rw_next        = SDA;
                        end else begin
                            bit_cnt_next = bit_cnt + 3'd1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_next = 1'b0;
                        if (accept) begin
                            state_next    = ACK;
                            sda_down_next = 1'b1;
                            match_next    = 1'b1;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        state_next    = DATA;
                        sda_down_next = 1'b0;
                        enable_next   = 1'b1;
                    end
                end
                DATA: begin
                    if (data_done) begin
                        state_next  = IGNORE;
                        enable_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_full  <= 1'b0;
            shreg      <= 8'h00;
            rw         <= 1'b0;
            enable     <= 1'b0;
            SDA_down   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            byte_full  <= byte_full_next;
            shreg      <= shreg_next;
            rw         <= rw_next;
            enable     <= enable_next;
            SDA_down   <= sda_down_next;
            addr_match <= match_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_slave_addr_frontend.sv
// Bench for i2c_slave_addr_frontend: a bus master drives directed and random transfers,
// a transaction-level model predicts every output each cycle.
module tb_i2c_slave_addr_frontend;
    localparam logic [6:0] ADDR = 7'h42;
    localparam int         SYNC = 2;
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif
    localparam int P_IDLE = 0, P_ADDR = 1, P_ACK = 2, P_DATA = 3, P_IGN = 4;

    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, data_done = 1'b0;
    logic sda_pin;
    logic SCL, SDA, SCL_prev, SDA_prev, enable, SDA_down, rw, addr_match, busy;

    assign sda_pin = sda_m & ~SDA_down;

    i2c_slave_addr_frontend #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(SYNC)) dut (
        .FPGA_clk(clk), .rst(rst), .SCL_in(scl_m), .SDA_in(sda_pin), .data_done(data_done),
        .SCL(SCL), .SDA(SDA), .SCL_prev(SCL_prev), .SDA_prev(SDA_prev), .enable(enable),
        .SDA_down(SDA_down), .rw(rw), .addr_match(addr_match), .busy(busy));

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_match = 0, n_down = 0, n_en = 0;

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 1'b0;
    bit scl_line[$], sda_line[$];
    int phase, nbits, byte_val;
    bit m_rw, m_en, m_down, m_match, m_busy;

    function automatic bit accepts(int b);
        return ((b / 2) == int'(ADDR) && (b % 2) == 0) || (GC && b == 0);
    endfunction

    task automatic model_reset();
        scl_line = {};
        sda_line = {};
        for (int i = 0; i <= SYNC; i++) begin
            scl_line.push_back(1'b1);
            sda_line.push_back(1'b1);
        end
        phase = P_IDLE; nbits = 0; byte_val = 0;
        m_rw = 0; m_en = 0; m_down = 0; m_match = 0; m_busy = 0;
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        bit sc, sp, dc, dp, rise, fall, st, sp_ev, raw_sda;
        if (rst) begin
            model_reset();
            return;
        end
        sc = scl_line[SYNC-1]; sp = scl_line[SYNC];
        dc = sda_line[SYNC-1]; dp = sda_line[SYNC];
        raw_sda = sda_m & ~m_down;
        rise  = !sp && sc;
        fall  = sp && !sc;
        st    = sp && sc && dp && !dc;
        sp_ev = sp && sc && !dp && dc;
        m_match = 0;
        if (sp_ev) begin
            phase = P_IDLE; nbits = 0; m_en = 0; m_down = 0;
        end else if (st) begin
            phase = P_ADDR; nbits = 0; byte_val = 0; m_en = 0; m_down = 0;
        end else if (phase == P_ADDR) begin
            if (rise && nbits < 8) begin
                byte_val = byte_val * 2 + int'(dc);
                nbits++;
                if (nbits == 8) m_rw = dc;
            end else if (fall && nbits == 8) begin
                nbits = 0;
                if (accepts(byte_val)) begin
                    phase = P_ACK; m_down = 1; m_match = 1;
                end else begin
                    phase = P_IGN;
                end
            end
        end else if (phase == P_ACK && fall) begin
            phase = P_DATA; m_down = 0; m_en = 1;
        end else if (phase == P_DATA && data_done) begin
            phase = P_IGN; m_en = 0;
        end
        m_busy = (phase != P_IDLE);
        scl_line.push_front(scl_m);
        sda_line.push_front(raw_sda);
        void'(scl_line.pop_back());
        void'(sda_line.pop_back());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_SCL", SCL, scl_line[SYNC-1]);
            chk("cyc_SDA", SDA, sda_line[SYNC-1]);
            chk("cyc_SCL_prev", SCL_prev, scl_line[SYNC]);
            chk("cyc_SDA_prev", SDA_prev, sda_line[SYNC]);
            chk("cyc_enable", enable, m_en);
            chk("cyc_SDA_down", SDA_down, m_down);
            chk("cyc_rw", rw, m_rw);
            chk("cyc_addr_match", addr_match, m_match);
            chk("cyc_busy", busy, m_busy);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (addr_match === 1'b1) n_match++;
        if (SDA_down === 1'b1) n_down++;
        if (enable === 1'b1) n_en++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bus master ----------------
    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hp();
        idle($urandom_range(5, 9));
    endtask

    task automatic do_start();
        sda_m = 1'b1; hp();
        scl_m = 1'b1; hp();
        sda_m = 1'b0; hp();
        scl_m = 1'b0; hp();
    endtask

    task automatic do_stop();
        sda_m = 1'b0; hp();
        scl_m = 1'b1; hp();
        sda_m = 1'b1; hp();
    endtask

    task automatic send_bit(bit b);
        sda_m = b; hp();
        scl_m = 1'b1; hp();
        scl_m = 1'b0; hp();
    endtask

    task automatic send_bits(logic [7:0] b, int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_addr(logic [7:0] b);
        bit exp;
        exp = accepts(int'(b));
        send_bits(b, 8);
        sda_m = 1'b1; hp();
        chk("ack_low", SDA_down, exp);
        scl_m = 1'b1; hp();
        chk("ack_high", SDA_down, exp);
        scl_m = 1'b0; hp();
        chk("ack_release", SDA_down, 1'b0);
        chk("enable_after_ack", enable, exp);
    endtask

    task automatic data_phase();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        send_bit(1'b1);
        idle($urandom_range(1, 6));
        data_done = 1'b1; idle(1);
        data_done = 1'b0; idle(1);
        chk("enable_after_done", enable, 1'b0);
    endtask

    int m0, d0, e0;
    logic [7:0] a;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst_SCL", SCL, 1'b1);
        chk("rst_SDA", SDA, 1'b1);
        chk("rst_SCL_prev", SCL_prev, 1'b1);
        chk("rst_SDA_prev", SDA_prev, 1'b1);
        chk("rst_enable", enable, 1'b0);
        chk("rst_SDA_down", SDA_down, 1'b0);
        chk("rst_rw", rw, 1'b0);
        chk("rst_busy", busy, 1'b0);
        idle(4);

        // clean write to 0x42
        m0 = n_match; d0 = n_down; e0 = n_en;
        do_start();
        chk("clean_busy_addr", busy, 1'b1);
        send_addr(8'h84);
        chk("clean_rw", rw, 1'b0);
        data_phase();
        chk("clean_busy_ignore", busy, 1'b1);
        do_stop();
        chk("clean_busy_stop", busy, 1'b0);
        chk_int("clean_match_pulses", n_match - m0, 1);
        chk("clean_down_seen", n_down > d0, 1'b1);
        chk("clean_enable_seen", n_en > e0, 1'b1);

        // address mismatch
        m0 = n_match; d0 = n_down; e0 = n_en;
        do_start();
        send_addr(8'h86);
        chk("mis_busy", busy, 1'b1);
        do_stop();
        chk("mis_busy_stop", busy, 1'b0);
        chk_int("mis_match", n_match - m0, 0);
        chk_int("mis_down", n_down - d0, 0);
        chk_int("mis_enable", n_en - e0, 0);

        // read request
        m0 = n_match; d0 = n_down; e0 = n_en;
        do_start();
        send_addr(8'h85);
        chk("read_rw", rw, 1'b1);
        chk("read_busy", busy, 1'b1);
        chk_int("read_down", n_down - d0, 0);
        chk_int("read_enable", n_en - e0, 0);
        do_stop();
        chk("read_busy_stop", busy, 1'b0);

        // STOP after 4 bits, then a full transaction
        m0 = n_match;
        do_start();
        send_bits(8'h84, 4);
        do_stop();
        chk("early_busy_stop", busy, 1'b0);
        do_start();
        send_addr(8'h84);
        data_phase();
        do_stop();
        chk_int("early_then_match", n_match - m0, 1);

        // repeated START mid-DATA
        m0 = n_match;
        do_start();
        send_addr(8'h84);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("rep_enable_data", enable, 1'b1);
        do_start();
        chk("rep_enable_dropped", enable, 1'b0);
        chk("rep_busy", busy, 1'b1);
        send_addr(8'h84);
        data_phase();
        do_stop();
        chk_int("rep_match", n_match - m0, 2);

        // reset while SDA_down is held
        do_start();
        send_bits(8'h84, 8);
        sda_m = 1'b1;
        idle(6);
        chk("rst_ack_held", SDA_down, 1'b1);
        rst = 1'b1; idle(1);
        rst = 1'b0;
        chk("rst_ack_released", SDA_down, 1'b0);
        chk("rst_ack_busy", busy, 1'b0);
        idle(4);
        do_stop();

        // general-call address
        m0 = n_match;
        do_start();
        send_addr(8'h00);
        data_phase();
        do_stop();
        chk_int("gcall_match", n_match - m0, GC ? 1 : 0);

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 5))
                0, 1: a = 8'h84;
                2: a = 8'h85;
                3: a = 8'h86;
                4: a = 8'h00;
                default: a = 8'($urandom_range(0, 255));
            endcase
            do_start();
            if ($urandom_range(0, 4) == 0) begin
                send_bits(a, $urandom_range(1, 7));
            end else begin
                send_addr(a);
                if (accepts(int'(a)) && $urandom_range(0, 2) == 0) begin
                    send_bit(1'($urandom_range(0, 1)));
                    do_start();
                    send_addr(8'h84);
                end
                data_phase();
            end
            do_stop();
            chk("rand_busy_stop", busy, 1'b0);
            idle($urandom_range(0, 5));
        end

        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
